exdes_icrc32_rx_check_8b: RTL and testbench

//  Receive-side CRC32 checker for the RDMA example-design byte stream: consumes 8-bit AXIS packets

---
 rtl/exdes_icrc32_rx_check_8b.sv | 182 ++++++++++++++++++
 tb/tb_exdes_icrc32_rx_check_8b.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exdes_icrc32_rx_check_8b.sv
// Receive-side CRC32 checker: strips the 4 trailing CRC bytes of each 8-bit AXIS packet,
// forwards the payload and reports a per-packet pass/fail/runt result.
module exdes_icrc32_rx_check_8b #(
  parameter logic [31:0] POLY      = 32'h04C1_1DB7,
  parameter logic [31:0] INIT_SEED = 32'hFFFF_FFFF,
  parameter logic [31:0] FINAL_XOR = 32'hFFFF_FFFF,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tvalid,
  input  logic             s_axis_tlast,
  output logic             s_axis_tready,
  output logic [7:0]       m_axis_tdata,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  input  logic             m_axis_tready,
  output logic             chk_valid,
  output logic             chk_ok,
  output logic             chk_runt,
  output logic [CNT_W-1:0] pkt_len,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, STREAM = 2'd2} state_t;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^ ({32{r[31] ^ d[i]}} & POLY);
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0][7:0]   dly_q, dly_d;
  logic [31:0]       crc_q, crc_d;
  logic [CNT_W-1:0]  pay_q, pay_d;
  logic [7:0]        mdata_q, mdata_d;
  logic              mvalid_q, mvalid_d;
  logic              mlast_q, mlast_d;
  logic              chkv_q, chkv_d;
  logic              chkok_q, chkok_d;
  logic              runt_q, runt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              run_q, run_d;

  logic              accept_s;
  logic [31:0]       step_s;
  logic [31:0]       rx_word_s;
  logic [CNT_W-1:0]  pay_inc_s;
  logic [CNT_W-1:0]  err_inc_s;

  // run_q keeps the input closed while reset is held and for the first cycle after it
  assign s_axis_tready = run_q & (~mvalid_q | m_axis_tready);
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign step_s        = crc_step(crc_q, dly_q[0]);
  assign rx_word_s     = {dly_q[1], dly_q[2], dly_q[3], s_axis_tdata};
  assign pay_inc_s     = (pay_q == {CNT_W{1'b1}}) ? pay_q : pay_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign err_inc_s     = (err_q == {CNT_W{1'b1}}) ? err_q : err_q + {{(CNT_W-1){1'b0}}, 1'b1};

  assign m_axis_tdata  = mdata_q;
  assign m_axis_tvalid = mvalid_q;
  assign m_axis_tlast  = mlast_q;
  assign chk_valid     = chkv_q;
  assign chk_ok        = chkok_q;
  assign chk_runt      = runt_q;
  assign pkt_len       = len_q;
  assign err_cnt       = err_q;

  // Next-state: delay line, CRC accumulation, output stage and per-packet result
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    crc_d    = crc_q;
    pay_d    = pay_q;
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    chkv_d   = 1'b0;
    chkok_d  = chkok_q;
    runt_d   = runt_q;
    len_d    = len_q;
    err_d    = err_q;
    run_d    = 1'b1;
    if (mvalid_q & m_axis_tready) begin
      mvalid_d = 1'b0;
    end else begin
      mvalid_d = mvalid_q;
    end
    if (accept_s) begin
      case (state_q)
        IDLE, FILL: begin
          if (s_axis_tlast) begin
            // Fewer than 5 bytes: nothing forwarded, report a runt
            chkv_d  = 1'b1;
            chkok_d = 1'b0;
            runt_d  = 1'b1;
            len_d   = {CNT_W{1'b0}};
            err_d   = err_inc_s;
            cnt_d   = 3'd0;
            crc_d   = INIT_SEED;
            pay_d   = {CNT_W{1'b0}};
            state_d = IDLE;
          end else begin
            dly_d[cnt_q[1:0]] = s_axis_tdata;
            cnt_d   = cnt_q + 3'd1;
            state_d = (cnt_q == 3'd3) ? STREAM : FILL;
          end
        end
        STREAM: begin
          mdata_d  = dly_q[0];
          mvalid_d = 1'b1;
          mlast_d  = s_axis_tlast;
          dly_d    = {s_axis_tdata, dly_q[3], dly_q[2], dly_q[1]};
          if (s_axis_tlast) begin
            chkv_d  = 1'b1;
            chkok_d = ((step_s ^ FINAL_XOR) == rx_word_s);
            runt_d  = 1'b0;
            len_d   = pay_inc_s;
            err_d   = ((step_s ^ FINAL_XOR) == rx_word_s) ? err_q : err_inc_s;
            cnt_d   = 3'd0;
            crc_d   = INIT_SEED;
            pay_d   = {CNT_W{1'b0}};
            state_d = IDLE;
          end else begin
            crc_d   = step_s;
            pay_d   = pay_inc_s;
          end
        end
        default: begin
          cnt_d   = 3'd0;
          crc_d   = INIT_SEED;
          pay_d   = {CNT_W{1'b0}};
          state_d = IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      dly_q    <= 32'h0000_0000;
      crc_q    <= INIT_SEED;
      pay_q    <= {CNT_W{1'b0}};
      mdata_q  <= 8'h00;
      mvalid_q <= 1'b0;
      mlast_q  <= 1'b0;
      chkv_q   <= 1'b0;
      chkok_q  <= 1'b0;
      runt_q   <= 1'b0;
      len_q    <= {CNT_W{1'b0}};
      err_q    <= {CNT_W{1'b0}};
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      crc_q    <= crc_d;
      pay_q    <= pay_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mlast_q  <= mlast_d;
      chkv_q   <= chkv_d;
      chkok_q  <= chkok_d;
      runt_q   <= runt_d;
      len_q    <= len_d;
      err_q    <= err_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: tb/tb_exdes_icrc32_rx_check_8b.sv
// Bench for the RX CRC32 checker: table of packets plus random back-to-back traffic and a
// mid-packet reset; payload bytes and check results are scoreboarded through queues.
module tb_exdes_icrc32_rx_check_8b;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b1;
  logic        chk_valid, chk_ok, chk_runt;
  logic [15:0] pkt_len, err_cnt;

  exdes_icrc32_rx_check_8b dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .chk_valid(chk_valid), .chk_ok(chk_ok), .chk_runt(chk_runt),
    .pkt_len(pkt_len), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] data; logic last; } byte_exp_t;
  typedef struct { logic ok; logic runt; int len; } chk_exp_t;
  typedef struct {
    int         len;      // payload length, or raw byte count for a runt
    logic [7:0] first;
    logic [7:0] step;
    int         flip;     // payload index whose bit 0 is flipped after CRC, -1 for none
    bit         runt;
    bit         exp_ok;
    int         exp_len;
  } vec_t;

  byte_exp_t exp_bytes[$];
  chk_exp_t  exp_chk[$];
  int total = 0;
  int bad = 0;
  int model_err = 0;
  bit rnd_rdy = 1'b0;

  // Reference CRC: shift the data byte LSB first against the register MSB
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic [7:0]  x;
    r = c;
    x = d;
    repeat (8) begin
      if (r[31] ^ x[0]) r = (r << 1) ^ 32'h04C1_1DB7;
      else              r = r << 1;
      x = x >> 1;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
    int  n;
    logic acc;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      acc = s_axis_tready;
      @(posedge clk); #1;
      if (acc) break;
      n++;
      if (n > 1000) begin
        total++; bad++;
        $display("FAIL accept_timeout actual=stalled required=accepted");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "input never accepted");
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Builds the packet, pushes its expectations, then drives it
  task automatic run_pkt(input logic [7:0] pl_in[$], input int flip, input bit runt,
                         input bit exp_ok, input int exp_len, input bit gaps);
    logic [7:0]  pl[$];
    logic [7:0]  pk[$];
    logic [31:0] crc;
    byte_exp_t   be;
    chk_exp_t    ce;
    pl = pl_in;
    if (runt) begin
      pk = pl;
    end else begin
      crc = 32'hFFFF_FFFF;
      foreach (pl[i]) crc = ref_crc(crc, pl[i]);
      crc = crc ^ 32'hFFFF_FFFF;
      if (flip >= 0) pl[flip] = pl[flip] ^ 8'h01;
      foreach (pl[i]) begin
        be.data = pl[i];
        be.last = (i == pl.size() - 1);
        exp_bytes.push_back(be);
      end
      pk = pl;
      pk.push_back(crc[31:24]); pk.push_back(crc[23:16]);
      pk.push_back(crc[15:8]);  pk.push_back(crc[7:0]);
    end
    ce.ok = exp_ok; ce.runt = runt; ce.len = exp_len;
    exp_chk.push_back(ce);
    foreach (pk[i]) send_byte(pk[i], i == pk.size() - 1, gaps);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_chk.size() != 0) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_bytes", exp_bytes.size(), 0);
    check("drain_chk", exp_chk.size(), 0);
  endtask

  // Downstream ready: always 1, or a coin toss per cycle in random mode
  initial begin
    forever begin
      @(posedge clk); #1;
      m_axis_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compare output bytes and check results against the queues
  initial begin
    byte_exp_t be;
    chk_exp_t  ce;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_bytes.size() == 0) begin
            check("unexpected_byte", 32'(m_axis_tdata), 32'hFFFF_FFFF);
          end else begin
            be = exp_bytes.pop_front();
            check("m_tdata", 32'(m_axis_tdata), 32'(be.data));
            check("m_tlast", 32'(m_axis_tlast), 32'(be.last));
          end
        end
        if (chk_valid) begin
          if (exp_chk.size() == 0) begin
            check("unexpected_chk", 32'(chk_valid), 32'h0);
          end else begin
            ce = exp_chk.pop_front();
            if (!ce.ok) model_err++;
            check("chk_ok", 32'(chk_ok), 32'(ce.ok));
            check("chk_runt", 32'(chk_runt), 32'(ce.runt));
            check("pkt_len", 32'(pkt_len), 32'(ce.len));
            check("err_cnt", 32'(err_cnt), 32'(model_err));
          end
        end
      end
    end
  end

  initial begin
    vec_t       vecs[6];
    logic [7:0] pl[$];
    byte_exp_t  be;

    vecs[0] = '{len: 16, first: 8'h01, step: 8'h01, flip: -1, runt: 0, exp_ok: 1, exp_len: 16};
    vecs[1] = '{len: 16, first: 8'h01, step: 8'h01, flip: 4,  runt: 0, exp_ok: 0, exp_len: 16};
    vecs[2] = '{len: 3,  first: 8'hAA, step: 8'h11, flip: -1, runt: 1, exp_ok: 0, exp_len: 0};
    vecs[3] = '{len: 1,  first: 8'h5A, step: 8'h00, flip: -1, runt: 0, exp_ok: 1, exp_len: 1};
    vecs[4] = '{len: 4,  first: 8'h10, step: 8'h01, flip: -1, runt: 1, exp_ok: 0, exp_len: 0};
    vecs[5] = '{len: 2,  first: 8'hC3, step: 8'h07, flip: -1, runt: 0, exp_ok: 1, exp_len: 2};

    // Reset state
    #23;
    check("rst_s_tready", 32'(s_axis_tready), 32'h0);
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("rst_chk_valid", 32'(chk_valid), 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_pkt_len", 32'(pkt_len), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven packets
    for (int v = 0; v < 6; v++) begin
      pl.delete();
      for (int i = 0; i < vecs[v].len; i++) pl.push_back(vecs[v].first + 8'(i) * vecs[v].step);
      run_pkt(pl, vecs[v].flip, vecs[v].runt, vecs[v].exp_ok, vecs[v].exp_len, 1'b0);
    end
    drain();
    check("err_after_table", 32'(err_cnt), 32'd3);

    // Random back-to-back traffic with stalls and gaps
    rnd_rdy = 1'b1;
    for (int p = 0; p < 100; p++) begin
      pl.delete();
      for (int i = 0; i < int'($urandom_range(1, 20)); i++) pl.push_back(8'($urandom));
      run_pkt(pl, -1, 1'b0, 1'b1, pl.size(), 1'b1);
    end
    drain();
    rnd_rdy = 1'b0;
    @(posedge clk); #1;

    // Reset mid-packet: 10 of 20 bytes, 6 payload bytes forwarded, no result
    for (int i = 0; i < 6; i++) begin
      be.data = 8'h80 + 8'(i); be.last = 1'b0;
      exp_bytes.push_back(be);
    end
    for (int i = 0; i < 10; i++) send_byte(8'h80 + 8'(i), 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_reset_bytes", exp_bytes.size(), 0);
    rst_n = 1'b0;
    #1;
    model_err = 0;
    check("mid_rst_s_tready", 32'(s_axis_tready), 32'h0);
    check("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
    check("mid_rst_chk_valid", 32'(chk_valid), 32'h0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'h40 + 8'(i));
    run_pkt(pl, -1, 1'b0, 1'b1, 20, 1'b0);
    drain();
    check("final_err_cnt", 32'(err_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
